// File: rtl/ysyx_22040127_memaccess.sv
// RV64 memory-access stage: byte-lane store/load formatting over a valid/ready data bus.
// Optional macro YSYX_22040127_MISALIGN_TRAP_EN turns misaligned accesses into out_exc traps.
module ysyx_22040127_memaccess #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [2:0]        in_funct3,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [4:0]        in_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [4:0]        out_rd,
    output logic              out_exc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [2:0]        funct3_q;
    logic              ld_q;
    logic              st_q;

    logic              accept;
    logic              mem_op;
    logic              misalign;
    logic [2:0]        off;
    logic [7:0]        lane_mask;
    logic [XLEN-1:0]   rshift;
    logic [XLEN-1:0]   load_data;

    assign accept = in_valid && (state == S_IDLE);
    assign mem_op = in_load || in_store;
    assign off    = addr_q[2:0];

`ifdef YSYX_22040127_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        if (mem_op) begin
            case (in_funct3[1:0])
                2'b01:   misalign = in_alu[0];
                2'b10:   misalign = |in_alu[1:0];
                2'b11:   misalign = |in_alu[2:0];
                default: misalign = 1'b0;
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (in_valid) state_nx = (mem_op && !misalign) ? S_REQ : S_DONE;
            S_REQ:  if (mem_req_ready) state_nx = S_WAIT;
            S_WAIT: if (mem_resp_valid) state_nx = S_DONE;
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (state == S_IDLE);
        mem_req_valid = (state == S_REQ);
        out_valid     = (state == S_DONE);
        mem_req_wen   = (state == S_REQ) && st_q;
        mem_req_wmask = (state == S_REQ) ? lane_mask : '0;
    end

    // Shifting within 8 bits drops lanes past 7, giving a truncated misaligned access.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   lane_mask = 8'h01 << off;
            2'b01:   lane_mask = 8'h03 << off;
            2'b10:   lane_mask = 8'h0F << off;
            default: lane_mask = 8'hFF;
        endcase
    end

    assign mem_req_addr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign mem_req_wdata = wdata_q << {off, 3'b000};
    assign rshift        = mem_resp_rdata >> {off, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){rshift[7]}},   rshift[7:0]};
            3'b001:  load_data = {{(XLEN-16){rshift[15]}}, rshift[15:0]};
            3'b010:  load_data = {{(XLEN-32){rshift[31]}}, rshift[31:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}},  rshift[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, rshift[15:0]};
            3'b110:  load_data = {{(XLEN-32){1'b0}}, rshift[31:0]};
            default: load_data = rshift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            ld_q     <= 1'b0;
            st_q     <= 1'b0;
            out_data <= '0;
            out_rd   <= '0;
            out_exc  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= in_alu[ADDR_W-1:0];
                wdata_q  <= in_wdata;
                funct3_q <= in_funct3;
                ld_q     <= in_load;
                st_q     <= in_store && !in_load;
                out_exc  <= misalign;
                if (misalign) begin
                    out_data <= in_alu;
                    out_rd   <= '0;
                end else if (in_load) begin
                    out_data <= '0;
                    out_rd   <= in_rd;
                end else if (in_store) begin
                    out_data <= '0;
                    out_rd   <= '0;
                end else begin
                    out_data <= in_alu;
                    out_rd   <= in_rd;
                end
            end
            if ((state == S_WAIT) && mem_resp_valid && ld_q) begin
                out_data <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040127_memaccess.sv
// Directed bench for ysyx_22040127_memaccess: vector table of single transactions plus
// hand-written stall, latching, stray-response and reset-in-WAIT sequences.
module tb_ysyx_22040127_memaccess;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_alu;
    logic [63:0] in_wdata;
    logic [2:0]  in_funct3;
    logic        in_load;
    logic        in_store;
    logic [4:0]  in_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_exc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22040127_memaccess #(.XLEN(64), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu(in_alu), .in_wdata(in_wdata),
        .in_funct3(in_funct3), .in_load(in_load), .in_store(in_store), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .out_exc(out_exc)
    );

    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [63:0] alu;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic [7:0]  exp_mask;
        logic [63:0] exp_wdata;
        logic [63:0] exp_data;
        logic [4:0]  exp_rd;
        logic        exp_exc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic ld, input logic st, input logic [2:0] f3,
                                input logic [63:0] alu, input logic [63:0] wdata, input logic [63:0] rdata,
                                input logic [4:0] rd, input logic exp_req, input logic [63:0] exp_addr,
                                input logic [7:0] exp_mask, input logic [63:0] exp_wdata,
                                input logic [63:0] exp_data, input logic [4:0] exp_rd, input logic exp_exc);
        vec_t v;
        v.name = name; v.ld = ld; v.st = st; v.f3 = f3; v.alu = alu; v.wdata = wdata;
        v.rdata = rdata; v.rd = rd; v.exp_req = exp_req; v.exp_addr = exp_addr;
        v.exp_mask = exp_mask; v.exp_wdata = exp_wdata; v.exp_data = exp_data;
        v.exp_rd = exp_rd; v.exp_exc = exp_exc;
        return v;
    endfunction

    task automatic drive_in(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [63:0] alu, input logic [63:0] wdata, input logic [4:0] rd);
        in_load = ld; in_store = st; in_funct3 = f3; in_alu = alu; in_wdata = wdata; in_rd = rd;
    endtask

    task automatic scramble_in();
        in_valid = 1'b0; in_alu = 64'hDEAD_BEEF_DEAD_BEEF; in_wdata = 64'hFFFF_0000_FFFF_0000;
        in_funct3 = 3'b101; in_rd = 5'd30; in_load = 1'b0; in_store = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive_in(v.ld, v.st, v.f3, v.alu, v.wdata, v.rd);
        in_valid = 1'b1;
        @(negedge clk);
        scramble_in();
        chk({v.name, ".req_valid"}, 64'(mem_req_valid), 64'(v.exp_req));
        if (v.exp_req) begin
            chk({v.name, ".addr"}, mem_req_addr, v.exp_addr);
            chk({v.name, ".wen"}, 64'(mem_req_wen), 64'(v.st & ~v.ld));
            if (v.st && !v.ld) begin
                chk({v.name, ".wmask"}, 64'(mem_req_wmask), 64'(v.exp_mask));
                chk({v.name, ".wdata"}, mem_req_wdata, v.exp_wdata);
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            chk({v.name, ".wait_no_out"}, 64'(out_valid), 64'd0);
            mem_resp_valid = 1'b1;
            mem_resp_rdata = v.rdata;
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
        end
        chk({v.name, ".out_valid"}, 64'(out_valid), 64'd1);
        chk({v.name, ".out_data"}, out_data, v.exp_data);
        chk({v.name, ".out_rd"}, 64'(out_rd), 64'(v.exp_rd));
        chk({v.name, ".out_exc"}, 64'(out_exc), 64'(v.exp_exc));
        chk({v.name, ".busy"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({v.name, ".idle_after"}, 64'(in_ready), 64'd1);
        chk({v.name, ".out_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_rdata = '0; out_ready = 1'b0;
        drive_in(1'b0, 1'b0, 3'b000, '0, '0, '0);

        // name ld st f3 alu wdata rdata rd | req addr mask wdata data rd exc
        vecs.push_back(mk("alu_pass", 0, 0, 3'b000, 64'h1234, 64'h0, 64'h0, 5'd5,
                          0, 64'h0, 8'h00, 64'h0, 64'h1234, 5'd5, 0));
        vecs.push_back(mk("alu_ones", 0, 0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 5'd31,
                          0, 64'h0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 0));
        vecs.push_back(mk("sb", 0, 1, 3'b000, 64'h8000_0003, 64'hAB, 64'h0, 5'd3,
                          1, 64'h8000_0000, 8'h08, 64'hAB00_0000, 64'h0, 5'd0, 0));
        vecs.push_back(mk("lb", 1, 0, 3'b000, 64'h8000_0006, 64'h0, 64'h0080_0000_0000_0000, 5'd7,
                          1, 64'h8000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 5'd7, 0));
        vecs.push_back(mk("lbu", 1, 0, 3'b100, 64'h8000_0006, 64'h0, 64'h0080_0000_0000_0000, 5'd8,
                          1, 64'h8000_0000, 8'h00, 64'h0, 64'h80, 5'd8, 0));
        vecs.push_back(mk("lw", 1, 0, 3'b010, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 5'd10,
                          1, 64'h8000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321, 5'd10, 0));
        vecs.push_back(mk("lwu", 1, 0, 3'b110, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 5'd11,
                          1, 64'h8000_0000, 8'h00, 64'h0, 64'h8765_4321, 5'd11, 0));
        vecs.push_back(mk("sd", 0, 1, 3'b011, 64'h1000, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd12,
                          1, 64'h1000, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd0, 0));
        vecs.push_back(mk("sh", 0, 1, 3'b001, 64'h1006, 64'hBEEF, 64'h0, 5'd13,
                          1, 64'h1000, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0, 5'd0, 0));
        vecs.push_back(mk("ld", 1, 0, 3'b011, 64'h2000, 64'h0, 64'h0123_4567_89AB_CDEF, 5'd9,
                          1, 64'h2000, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 5'd9, 0));
        vecs.push_back(mk("lh", 1, 0, 3'b001, 64'h2002, 64'h0, 64'h0000_0000_8001_0000, 5'd14,
                          1, 64'h2000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 5'd14, 0));
        vecs.push_back(mk("lhu", 1, 0, 3'b101, 64'h2002, 64'h0, 64'h0000_0000_8001_0000, 5'd15,
                          1, 64'h2000, 8'h00, 64'h0, 64'h8001, 5'd15, 0));
        vecs.push_back(mk("ld_and_st", 1, 1, 3'b011, 64'h3000, 64'h1111, 64'h55AA_55AA_0F0F_F0F0, 5'd4,
                          1, 64'h3000, 8'h00, 64'h0, 64'h55AA_55AA_0F0F_F0F0, 5'd4, 0));
        vecs.push_back(mk("f3_111", 1, 0, 3'b111, 64'h3008, 64'h0, 64'hF000_0000_0000_0001, 5'd6,
                          1, 64'h3008, 8'h00, 64'h0, 64'hF000_0000_0000_0001, 5'd6, 0));
`ifdef YSYX_22040127_MISALIGN_TRAP_EN
        vecs.push_back(mk("sw_mis", 0, 1, 3'b010, 64'h8000_0006, 64'h1122_3344, 64'h0, 5'd16,
                          0, 64'h0, 8'h00, 64'h0, 64'h8000_0006, 5'd0, 1));
        vecs.push_back(mk("lh_mis", 1, 0, 3'b001, 64'h8000_0001, 64'h0, 64'h0000_0000_00CD_AB00, 5'd17,
                          0, 64'h0, 8'h00, 64'h0, 64'h8000_0001, 5'd0, 1));
`else
        vecs.push_back(mk("sw_mis", 0, 1, 3'b010, 64'h8000_0006, 64'h1122_3344, 64'h0, 5'd16,
                          1, 64'h8000_0000, 8'hC0, 64'h3344_0000_0000_0000, 64'h0, 5'd0, 0));
        vecs.push_back(mk("lh_mis", 1, 0, 3'b001, 64'h8000_0001, 64'h0, 64'h0000_0000_00CD_AB00, 5'd17,
                          1, 64'h8000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_CDAB, 5'd17, 0));
`endif

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst.wen", 64'(mem_req_wen), 64'd0);
        chk("rst.wmask", 64'(mem_req_wmask), 64'd0);
        chk("rst.out_data", out_data, 64'd0);
        chk("rst.out_rd", 64'(out_rd), 64'd0);
        chk("rst.out_exc", 64'(out_exc), 64'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Passthrough held in DONE for 3 cycles; in_valid stays high but must not be taken
        @(negedge clk);
        drive_in(1'b0, 1'b0, 3'b000, 64'h1234, 64'h0, 5'd5);
        in_valid = 1'b1;
        @(negedge clk);
        drive_in(1'b0, 1'b0, 3'b000, 64'h9999, 64'h0, 5'd9);
        for (int c = 0; c < 3; c++) begin
            chk("stall.out_valid", 64'(out_valid), 64'd1);
            chk("stall.out_data", out_data, 64'h1234);
            chk("stall.out_rd", 64'(out_rd), 64'd5);
            chk("stall.in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall.released", 64'(in_ready), 64'd1);

        // Store byte with mem_req_ready delayed 2 cycles: request must stay stable
        @(negedge clk);
        drive_in(1'b0, 1'b1, 3'b000, 64'h8000_0003, 64'hAB, 5'd3);
        in_valid = 1'b1;
        @(negedge clk);
        scramble_in();
        for (int c = 0; c < 3; c++) begin
            chk("sbhold.valid", 64'(mem_req_valid), 64'd1);
            chk("sbhold.addr", mem_req_addr, 64'h8000_0000);
            chk("sbhold.wmask", 64'(mem_req_wmask), 64'h08);
            chk("sbhold.wdata", mem_req_wdata, 64'hAB00_0000);
            chk("sbhold.wen", 64'(mem_req_wen), 64'd1);
            if (c == 2) mem_req_ready = 1'b1;
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        chk("sbhold.req_drop", 64'(mem_req_valid), 64'd0);
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("sbhold.done", 64'(out_valid), 64'd1);
        chk("sbhold.out_rd", 64'(out_rd), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Response during REQ is ignored; only the response in WAIT counts
        @(negedge clk);
        drive_in(1'b1, 1'b0, 3'b011, 64'h4000, 64'h0, 5'd20);
        in_valid = 1'b1;
        @(negedge clk);
        scramble_in();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("stray.still_req", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("stray.waiting", 64'(out_valid), 64'd0);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h0000_1111_2222_3333;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("stray.out_valid", 64'(out_valid), 64'd1);
        chk("stray.out_data", out_data, 64'h0000_1111_2222_3333);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset while in WAIT abandons the load; the late response is ignored
        @(negedge clk);
        drive_in(1'b1, 1'b0, 3'b011, 64'h5000, 64'h0, 5'd21);
        in_valid = 1'b1;
        @(negedge clk);
        scramble_in();
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rstwait.in_ready", 64'(in_ready), 64'd1);
        chk("rstwait.req_valid", 64'(mem_req_valid), 64'd0);
        chk("rstwait.out_valid", 64'(out_valid), 64'd0);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h7777_7777_7777_7777;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("rstwait.ignored_valid", 64'(out_valid), 64'd0);
        chk("rstwait.ignored_ready", 64'(in_ready), 64'd1);
        chk("rstwait.out_data", out_data, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ysyx_22040127_memaccess.md
Name: ysyx_22040127_memaccess

Overview:
- Memory-access stage of the RV64 core, directly downstream of the execute stage.
- Consumes the ALU result (effective address or writeback value), store data and funct3.
- Performs loads and stores over a valid/ready data-memory port and delivers the writeback value to the WB stage over a valid/ready handshake.
- Non-memory instructions pass through in one cycle.

Parameters:
- XLEN, 64, datapath width.
- ADDR_W, 64, memory address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept new instruction
- in_alu  in  64  ALU output (address for ld/st, result otherwise)
- in_wdata  in  64  store source (rs2)
- in_funct3  in  3  size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
- in_load  in  1  load instruction
- in_store  in  1  store instruction
- in_rd  in  5  destination register
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  64  8-byte-aligned address
- mem_req_wen  out  1  1 = write
- mem_req_wdata  out  64  lane-shifted store data
- mem_req_wmask  out  8  byte enables
- mem_resp_valid  in  1  read data/write ack valid
- mem_resp_rdata  in  64  raw 64-bit read word
- out_valid  out  1  result to WB valid
- out_ready  in  1  WB accepts
- out_data  out  64  writeback value
- out_rd  out  5  destination register (0 for stores)
- out_exc  out  1  misaligned-access flag

Behaviour:
- Reset (rst==0 at posedge): state IDLE; in_ready=1; mem_req_valid=0; mem_req_wen=0; mem_req_wmask=0; out_valid=0; out_data=0; out_rd=0; out_exc=0. A reset mid-transaction abandons it; any later mem_resp_valid is ignored until a new request is issued.
- in_ready=1 only in IDLE. Accept occurs when in_valid and in_ready are both 1; inputs are latched on accept.
- States:
  - IDLE.
  - REQ: mem_req_valid held high with stable fields until mem_req_ready.
  - WAIT: awaiting mem_resp_valid.
  - DONE: out_valid held until out_ready.
- Transitions:
  - IDLE accept, neither load nor store: go to DONE. out_data=in_alu, out_rd=in_rd. Latency 1 cycle.
  - IDLE accept, load or store: go to REQ. Handshake in the same cycle it is raised is allowed.
  - REQ with mem_req_ready: go to WAIT.
  - WAIT with mem_resp_valid: go to DONE. Loads capture formatted data.
  - DONE with out_ready: go to IDLE. No back-to-back accept in the DONE cycle.
- Lane rules, with off=addr[2:0]:
  - mem_req_addr = {addr[63:3],3'b0}.
  - wmask: b = 8'h01<<off; h = 8'h03<<off; w = 8'h0F<<off; d = 8'hFF.
  - wdata = in_wdata << (8*off).
  - Load: shifted = rdata >> (8*off), then zero- or sign-extend per funct3 to 64 bits.
- Stores: out_rd=0, out_data=0.
- If in_load and in_store are both set, treat as load.
- mem_resp_valid outside WAIT is ignored.
- Unused funct3 111: handled as d.

Optional Feature:
- Macro: YSYX_22040127_MISALIGN_TRAP_EN.
- Defined:
  - Misalignment rules: h with addr[0]!=0, w with addr[1:0]!=0, or d with addr[2:0]!=0 is misaligned.
  - A misaligned access issues no bus request. The stage goes IDLE to DONE with out_exc=1, out_rd=0, out_data=in_alu (the faulting address).
- Not defined:
  - out_exc is tied 0.
  - Misaligned accesses are issued, with shifted mask bits beyond lane 7 dropped (truncated access).

Test Plan:
1. Reset, then rst=1 -> in_ready=1, out_valid=0, mem_req_valid=0, out_data=0.
2. ALU passthrough: in_alu=64'h1234, in_rd=5, no ld/st -> next cycle out_valid=1, out_data=64'h1234, out_rd=5; out_ready held 0 for 3 cycles -> outputs stable, in_ready=0.
3. Store byte: in_alu=64'h8000_0003, in_wdata=64'hAB, funct3=000 -> mem_req_addr=64'h8000_0000, wmask=8'h08, wdata=64'hAB000000, wen=1; mem_req_ready delayed 2 cycles -> request held stable.
4. Load byte signed: addr 64'h8000_0006, rdata=64'h0080_0000_0000_0000, funct3=000 -> out_data=64'hFFFF_FFFF_FFFF_FF80; funct3=100 -> out_data=64'h80.
5. Load word: addr offset 4, rdata=64'h8765_4321_0000_0000, funct3=010 -> out_data=64'hFFFF_FFFF_8765_4321; funct3=110 -> 64'h8765_4321.
6. With YSYX_22040127_MISALIGN_TRAP_EN: load h at addr 64'h8000_0001 -> no mem_req_valid, out_exc=1, out_data=64'h8000_0001. Also assert rst=0 while in WAIT -> IDLE next cycle and the stray resp is ignored.
